// File: rtl/lut_mac_defs.sv
// lut_mac_defs: shared FSM state encoding and default widths for the LUT MAC accumulate path
package lut_mac_defs;
    localparam int STATE_W = 2;
    localparam int DEF_PROD_W = 8;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/lut_mac_adder.sv
// lut_mac_adder: ACC_W-bit accumulate adder returning sum and carry-out
// LUT_MAC_SATURATE_EN: clamp the sum to all-ones on carry-out instead of wrapping
module lut_mac_adder #(
    parameter int ACC_W  = 10,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W-1:0] raw;
    always_comb begin
        {carry, raw} = {1'b0, acc} + (ACC_W+1)'(product);
`ifdef LUT_MAC_SATURATE_EN
        sum = carry ? '1 : raw;
`else
        sum = raw;
`endif
    end
endmodule

// File: rtl/lut_mac_accumulator.sv
// lut_mac_accumulator: sums LEN handshaked products and presents the total on a valid/ready port
// LUT_MAC_SATURATE_EN (in lut_mac_adder): saturating instead of wrapping accumulation
module lut_mac_accumulator
    import lut_mac_defs::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int LEN    = 4,
    parameter int ACC_W  = 10,
    localparam int CNT_W = $clog2(LEN) + 1
) (
    input  logic              clk_mac,
    input  logic              reset_mac,
    input  logic              start_mac,
    input  logic [PROD_W-1:0] product_in,
    input  logic              product_valid,
    output logic              product_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [CNT_W-1:0]  count_out,
    output logic              busy,
    output logic              overflow
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    lut_mac_adder #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_adder (
        .acc     (acc),
        .product (product_in),
        .sum     (add_sum),
        .carry   (add_carry)
    );
    assign product_ready = (state == ACCUM);
    assign busy          = (state != IDLE);
    always_ff @(posedge clk_mac) begin
        if (reset_mac) begin
            state     <= IDLE;
            acc       <= '0;
            count_out <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_mac) begin
                    state     <= ACCUM;
                    acc       <= '0;
                    count_out <= '0;
                    overflow  <= 1'b0;
                end
                ACCUM: if (product_valid) begin
                    acc       <= add_sum;
                    count_out <= count_out + 1'b1;
                    overflow  <= overflow | add_carry;
                    if (count_out == LAST) begin
                        state     <= DONE;
                        sum_out   <= add_sum;
                        sum_valid <= 1'b1;
                    end
                end
                DONE: if (sum_ready) begin
                    sum_valid <= 1'b0;
                    state     <= start_mac ? ACCUM : IDLE;
                    // back-to-back run: clear the run state in the same edge
                    if (start_mac) begin
                        acc       <= '0;
                        count_out <= '0;
                        overflow  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_mac_accumulator.sv
// tb_lut_mac_accumulator: directed and random runs checked against an arithmetic sum model
module tb_lut_mac_accumulator;
    logic       clk_mac = 1'b0;
    logic       reset_mac = 1'b1;
    logic       start_mac = 1'b0;
    logic [7:0] product_in = '0;
    logic       product_valid = 1'b0;
    logic       product_ready;
    logic [9:0] sum_out;
    logic       sum_valid;
    logic       sum_ready = 1'b0;
    logic [2:0] count_out;
    logic       busy;
    logic       overflow;

    logic       s_start = 1'b0;
    logic [7:0] s_prod = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_sum;
    logic       s_sum_valid;
    logic       s_sum_ready = 1'b0;
    logic [1:0] s_count;
    logic       s_busy;
    logic       s_ovf;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] prods [4];

    always #5 clk_mac = ~clk_mac;

    lut_mac_accumulator #(.PROD_W(8), .LEN(4), .ACC_W(10)) u_dut (
        .clk_mac(clk_mac), .reset_mac(reset_mac), .start_mac(start_mac),
        .product_in(product_in), .product_valid(product_valid), .product_ready(product_ready),
        .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .count_out(count_out), .busy(busy), .overflow(overflow)
    );

    lut_mac_accumulator #(.PROD_W(8), .LEN(2), .ACC_W(8)) u_small (
        .clk_mac(clk_mac), .reset_mac(reset_mac), .start_mac(s_start),
        .product_in(s_prod), .product_valid(s_valid), .product_ready(s_ready),
        .sum_out(s_sum), .sum_valid(s_sum_valid), .sum_ready(s_sum_ready),
        .count_out(s_count), .busy(s_busy), .overflow(s_ovf)
    );

    function automatic int model_sum(input int total, input int w);
        int lim = 1 << w;
`ifdef LUT_MAC_SATURATE_EN
        return (total >= lim) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] p);
        int t = 0;
        product_in = p;
        product_valid = 1'b1;
        while (!product_ready && t < 20) begin
            @(negedge clk_mac);
            t++;
        end
        chk("send_ready", product_ready, 1);
        @(negedge clk_mac);
        product_valid = 1'b0;
    endtask

    task automatic start_run();
        start_mac = 1'b1;
        @(negedge clk_mac);
        start_mac = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", product_ready, 1);
        chk("start_count", count_out, 0);
    endtask

    task automatic feed(input int gap);
        int total = 0;
        for (int i = 0; i < 4; i++) begin
            send(prods[i]);
            total += prods[i];
            chk("count_step", count_out, i + 1);
            if (i < 3) begin
                chk("no_early_valid", sum_valid, 0);
                repeat (gap) @(negedge clk_mac);
                chk("count_hold", count_out, i + 1);
            end
        end
        chk("sum_valid", sum_valid, 1);
        chk("sum_out", sum_out, model_sum(total, 10));
        chk("overflow", overflow, total > 1023);
        chk("count_done", count_out, 4);
        chk("done_not_ready", product_ready, 0);
    endtask

    task automatic finish_run();
        logic [9:0] held = sum_out;
        sum_ready = 1'b1;
        @(negedge clk_mac);
        sum_ready = 1'b0;
        chk("after_ack_valid", sum_valid, 0);
        chk("after_ack_busy", busy, 0);
        chk("after_ack_sum_kept", sum_out, held);
    endtask

    task automatic small_run(input logic [7:0] a, input logic [7:0] b);
        int total = a + b;
        s_start = 1'b1;
        @(negedge clk_mac);
        s_start = 1'b0;
        chk("s_ready", s_ready, 1);
        s_prod = a;
        s_valid = 1'b1;
        @(negedge clk_mac);
        s_prod = b;
        @(negedge clk_mac);
        s_valid = 1'b0;
        chk("s_sum_valid", s_sum_valid, 1);
        chk("s_sum", s_sum, model_sum(total, 8));
        chk("s_ovf", s_ovf, total > 255);
        chk("s_count", s_count, 2);
        s_sum_ready = 1'b1;
        @(negedge clk_mac);
        s_sum_ready = 1'b0;
        chk("s_idle", s_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_mac);
        reset_mac = 1'b0;
        chk("rst_sum", sum_out, 0);
        chk("rst_valid", sum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", product_ready, 0);
        chk("rst_count", count_out, 0);
        chk("rst_ovf", overflow, 0);

        prods = '{8'd225, 8'd225, 8'd225, 8'd225};
        start_run();
        feed(0);
        finish_run();

        prods = '{8'd3, 8'd0, 8'd7, 8'd1};
        start_run();
        feed(2);
        start_mac = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_mac);
            start_mac = 1'b0;
            chk("hold_valid", sum_valid, 1);
            chk("hold_sum", sum_out, 11);
            chk("hold_not_ready", product_ready, 0);
        end
        sum_ready = 1'b1;
        start_mac = 1'b1;
        @(negedge clk_mac);
        sum_ready = 1'b0;
        start_mac = 1'b0;
        chk("b2b_ready", product_ready, 1);
        chk("b2b_count", count_out, 0);
        chk("b2b_valid", sum_valid, 0);
        chk("b2b_sum_kept", sum_out, 11);
        prods = '{8'd10, 8'd20, 8'd30, 8'd40};
        feed(0);
        finish_run();

        start_run();
        send(8'd50);
        send(8'd60);
        reset_mac = 1'b1;
        @(negedge clk_mac);
        reset_mac = 1'b0;
        chk("mid_rst_sum", sum_out, 0);
        chk("mid_rst_count", count_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", product_ready, 0);
        chk("mid_rst_valid", sum_valid, 0);
        prods = '{8'd1, 8'd1, 8'd1, 8'd1};
        start_run();
        feed(0);
        finish_run();

        prods = '{8'd5, 8'd6, 8'd7, 8'd8};
        start_run();
        send(prods[0]);
        start_mac = 1'b1;
        @(negedge clk_mac);
        start_mac = 1'b0;
        chk("ign_start_count", count_out, 1);
        chk("ign_start_busy", product_ready, 1);
        for (int i = 1; i < 4; i++) send(prods[i]);
        chk("ign_start_sum", sum_out, 26);
        chk("ign_start_valid", sum_valid, 1);
        finish_run();

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) prods[i] = 8'($urandom_range(0, 255));
            start_run();
            feed($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(negedge clk_mac);
            chk("rand_hold_valid", sum_valid, 1);
            finish_run();
        end

        small_run(8'd200, 8'd100);
        small_run(8'd100, 8'd50);
        small_run(8'd255, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
